// File: rtl/sram_bus_arbiter_if.sv
// Command/ack signals of the two requesters plus the SRAM pins and the pad-buffer
// connections of the shared data bus.
interface sram_bus_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18
);
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [1:0]        ack_o;
    logic [DATA_W-1:0] rdata_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic              bus_t;
    logic [DATA_W-1:0] bus_o;
    logic [DATA_W-1:0] bus_i;

    modport slave (
        input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, bus_i,
        output ack_o, rdata_o, sram_addr_o, sram_we_n, sram_oe_n, bus_t, bus_o
    );

    modport master (
        output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, bus_i,
        input  ack_o, rdata_o, sram_addr_o, sram_we_n, sram_oe_n, bus_t, bus_o
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Round-robin arbiter sharing one bidirectional SRAM data bus between two requesters,
// with turnaround cycles on read/write direction changes. All outputs are registered.
module sram_bus_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 18,
    parameter int READ_LAT = 2,
    parameter int TURN_CYC = 1
) (
    input  logic              clock,
    input  logic              reset,
    sram_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TURN, WRITE, READ} state_t;

    localparam int MAX_CNT = (READ_LAT > TURN_CYC) ? READ_LAT : TURN_CYC;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              rr_ptr;
    logic              last_we;

    logic              lat_port;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;

    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              bus_t_q, bus_t_d;
    logic [DATA_W-1:0] bus_o_q, bus_o_d;

    logic [1:0]        eligible;
    logic              grant;
    logic              gnt_port;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic              turn_needed;
    logic              read_done;

    // A port whose ack is on the wire this cycle still holds its old request; mask it.
    always_comb begin
        eligible    = bus.req_i & ~ack_q;
        grant       = (state == IDLE) && (eligible != 2'b00);
        gnt_port    = (eligible == 2'b11) ? rr_ptr : eligible[1];
        gnt_we      = gnt_port ? bus.we_i[1]    : bus.we_i[0];
        gnt_addr    = gnt_port ? bus.addr1_i    : bus.addr0_i;
        gnt_wdata   = gnt_port ? bus.wdata1_i   : bus.wdata0_i;
        turn_needed = (TURN_CYC > 0) && (gnt_we != last_we);
        read_done   = (state == READ) && (cnt == READ_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    if (turn_needed) next_state = TURN;
                    else             next_state = gnt_we ? WRITE : READ;
                end
            end
            TURN:    if (cnt == TURN_LAST) next_state = lat_we ? WRITE : READ;
            WRITE:   next_state = IDLE;
            READ:    if (cnt == READ_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output flops are loaded from the state being entered, so each pin is glitch-free
    // and already valid for the whole first cycle of that state.
    always_comb begin
        bus_t_d = (next_state != WRITE);
        we_n_d  = (next_state != WRITE);
        oe_n_d  = (next_state != READ);
        bus_o_d = bus_o_q;
        if (next_state == WRITE) bus_o_d = (state == IDLE) ? gnt_wdata : lat_wdata;
        addr_d  = grant ? gnt_addr : addr_q;
        ack_d   = 2'b00;
        rdata_d = rdata_q;
        if (state == WRITE) ack_d = lat_port ? 2'b10 : 2'b01;
        if (read_done) begin
            ack_d   = lat_port ? 2'b10 : 2'b01;
            rdata_d = bus.bus_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ack_q   <= 2'b00;
            rdata_q <= '0;
            addr_q  <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            bus_t_q <= 1'b1;
            bus_o_q <= '0;
            rr_ptr  <= 1'b0;
            last_we <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            bus_t_q <= bus_t_d;
            bus_o_q <= bus_o_d;
            if (grant) rr_ptr <= ~gnt_port;
            if (state == WRITE)  last_we <= 1'b1;
            else if (read_done)  last_we <= 1'b0;
        end
    end

    // NOTE: the command latch is only read after a grant has loaded it, so it needs no reset.
    always_ff @(posedge clock) begin
        if (grant) begin
            lat_port  <= gnt_port;
            lat_we    <= gnt_we;
            lat_wdata <= gnt_wdata;
        end
    end

    assign bus.ack_o       = ack_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.sram_addr_o = addr_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.bus_t       = bus_t_q;
    assign bus.bus_o       = bus_o_q;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed and randomised checks of sram_bus_arbiter against an SRAM pin model and a
// transaction-level memory/requester model.
module tb_sram_bus_arbiter;
    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 18;
    localparam int READ_LAT     = 2;
    localparam int STARVE_LIMIT = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_bus_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus  ();
    sram_bus_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus2 ();

    sram_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .TURN_CYC(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    sram_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .TURN_CYC(2)) dut_t2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] sram_mem  [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] sram_mem2 [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ref_mem   [logic [ADDR_W-1:0]];

    // Requester model: one outstanding command per port.
    logic              pend   [2];
    logic              p_we   [2];
    logic [ADDR_W-1:0] p_addr [2];
    logic [DATA_W-1:0] p_wdata[2];
    int                wait_cnt[2];
    logic [DATA_W-1:0] exp_rdata;
    int                n_issued = 0;
    int                n_acked  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] sram_rd(input logic [ADDR_W-1:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : '0;
    endfunction

    function automatic logic [DATA_W-1:0] sram2_rd(input logic [ADDR_W-1:0] a);
        return sram_mem2.exists(a) ? sram_mem2[a] : '0;
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // SRAM pins: store on write strobe, return data while output enable is low, junk otherwise.
    task automatic sram_step();
        if (!bus.sram_we_n) sram_mem[bus.sram_addr_o] = bus.bus_o;
        bus.bus_i = !bus.sram_oe_n ? sram_rd(bus.sram_addr_o) : DATA_W'($urandom);
        if (!bus2.sram_we_n) sram_mem2[bus2.sram_addr_o] = bus2.bus_o;
        bus2.bus_i = !bus2.sram_oe_n ? sram2_rd(bus2.sram_addr_o) : DATA_W'($urandom);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        sram_step();
    endtask

    task automatic drive_random(input bit issue_en);
        for (int p = 0; p < 2; p++) begin
            if (issue_en && !pend[p] && $urandom_range(0, 3) == 0) begin
                pend[p]     = 1'b1;
                p_we[p]     = 1'($urandom);
                p_addr[p]   = 18'h20000 | ADDR_W'($urandom_range(0, 15));
                p_wdata[p]  = DATA_W'($urandom);
                wait_cnt[p] = 0;
                n_issued++;
            end
        end
        bus.req_i    = {pend[1], pend[0]};
        bus.we_i     = {p_we[1], p_we[0]};
        bus.addr0_i  = p_addr[0];
        bus.addr1_i  = p_addr[1];
        bus.wdata0_i = p_wdata[0];
        bus.wdata1_i = p_wdata[1];
    endtask

    task automatic monitor_cycle();
        bit read_ack;
        check("inv_drive_with_oe", !bus.bus_t && !bus.sram_oe_n, 1'b0);
        check("inv_we_with_oe", !bus.sram_we_n && !bus.sram_oe_n, 1'b0);
        check("inv_drive_only_in_write", !bus.bus_t && bus.sram_we_n, 1'b0);
        check("inv_single_ack", bus.ack_o == 2'b11, 1'b0);
        read_ack = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (bus.ack_o[p]) begin
                check("ack_has_request", pend[p], 1'b1);
                if (pend[p]) begin
                    if (p_we[p]) begin
                        ref_mem[p_addr[p]] = p_wdata[p];
                        check("write_reached_sram", sram_rd(p_addr[p]), p_wdata[p]);
                    end else begin
                        exp_rdata = ref_rd(p_addr[p]);
                        check("read_data", bus.rdata_o, exp_rdata);
                        read_ack = 1'b1;
                    end
                    pend[p] = 1'b0;
                    n_acked++;
                end
            end
        end
        if (!read_ack) check("rdata_hold", bus.rdata_o, exp_rdata);
        for (int p = 0; p < 2; p++) begin
            if (pend[p]) begin
                wait_cnt[p]++;
                check("starvation", wait_cnt[p] > STARVE_LIMIT, 1'b0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks_seen;
        int last_ack_cyc;
        int released;

        bus.req_i = '0;  bus.we_i = '0;  bus.addr0_i = '0;  bus.addr1_i = '0;
        bus.wdata0_i = '0;  bus.wdata1_i = '0;  bus.bus_i = '0;
        bus2.req_i = '0; bus2.we_i = '0; bus2.addr0_i = '0; bus2.addr1_i = '0;
        bus2.wdata0_i = '0; bus2.wdata1_i = '0; bus2.bus_i = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; wait_cnt[p] = 0;
        end
        exp_rdata = '0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_bus_t", bus.bus_t, 1'b1);
        check("rst_we_n", bus.sram_we_n, 1'b1);
        check("rst_oe_n", bus.sram_oe_n, 1'b1);
        check("rst_ack", bus.ack_o, 2'b00);
        check("rst_rdata", bus.rdata_o, 16'h0);
        check("rst_addr", bus.sram_addr_o, 18'h0);
        check("rst_bus_o", bus.bus_o, 16'h0);
        reset = 1'b0;

        // Port 0 read, no turnaround after reset: oe_n low two cycles, ack at grant+3
        sram_mem[18'h00010] = 16'hBEEF;
        bus.req_i = 2'b01; bus.we_i = 2'b00; bus.addr0_i = 18'h00010;
        tick();
        check("t1_oe_c1", bus.sram_oe_n, 1'b0);
        check("t1_bus_t_c1", bus.bus_t, 1'b1);
        check("t1_addr", bus.sram_addr_o, 18'h00010);
        check("t1_ack_c1", bus.ack_o, 2'b00);
        tick();
        check("t1_oe_c2", bus.sram_oe_n, 1'b0);
        check("t1_ack_c2", bus.ack_o, 2'b00);
        tick();
        check("t1_ack", bus.ack_o, 2'b01);
        check("t1_rdata", bus.rdata_o, 16'hBEEF);
        check("t1_oe_off", bus.sram_oe_n, 1'b1);

        // Port 1 write right after the read: one turnaround cycle, then one drive cycle
        bus.req_i = 2'b10; bus.we_i = 2'b10; bus.addr1_i = 18'h3FFFF; bus.wdata1_i = 16'h1234;
        tick();
        check("t2_turn_bus_t", bus.bus_t, 1'b1);
        check("t2_turn_we_n", bus.sram_we_n, 1'b1);
        check("t2_turn_oe_n", bus.sram_oe_n, 1'b1);
        check("t2_turn_ack", bus.ack_o, 2'b00);
        tick();
        check("t2_wr_bus_t", bus.bus_t, 1'b0);
        check("t2_wr_we_n", bus.sram_we_n, 1'b0);
        check("t2_wr_oe_n", bus.sram_oe_n, 1'b1);
        check("t2_wr_bus_o", bus.bus_o, 16'h1234);
        check("t2_wr_addr", bus.sram_addr_o, 18'h3FFFF);
        tick();
        check("t2_ack", bus.ack_o, 2'b10);
        check("t2_released", bus.bus_t, 1'b1);
        check("t2_we_off", bus.sram_we_n, 1'b1);
        check("t2_rdata_kept", bus.rdata_o, 16'hBEEF);
        check("t2_sram_written", sram_rd(18'h3FFFF), 16'h1234);

        // Both ports reading continuously: acks alternate 0,1,0,1,... at READ_LAT+1 spacing
        sram_mem[18'h00100] = 16'hA000;
        sram_mem[18'h00200] = 16'hB000;
        bus.req_i = 2'b11; bus.we_i = 2'b00; bus.addr0_i = 18'h00100; bus.addr1_i = 18'h00200;
        acks_seen = 0;
        last_ack_cyc = 0;
        for (int c = 0; c < 60 && acks_seen < 6; c++) begin
            tick();
            if (bus.ack_o != 2'b00) begin
                check("t3_onehot", $countones(bus.ack_o), 1);
                check("t3_order", bus.ack_o, (acks_seen % 2 == 0) ? 2'b01 : 2'b10);
                check("t3_rdata", bus.rdata_o, (acks_seen % 2 == 0) ? 16'hA000 : 16'hB000);
                if (acks_seen >= 1) check("t3_spacing", c - last_ack_cyc, READ_LAT + 1);
                last_ack_cyc = c;
                acks_seen++;
                if (acks_seen == 6) bus.req_i = 2'b00;
            end
        end
        check("t3_ack_count", acks_seen, 6);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("t3_quiet", bus.ack_o, 2'b00);
        end

        // Write then read with TURN_CYC=2 on the second instance
        bus2.req_i = 2'b01; bus2.we_i = 2'b01; bus2.addr0_i = 18'h00005; bus2.wdata0_i = 16'hA5A5;
        tick();
        check("t4_turn_w1", bus2.bus_t && bus2.sram_we_n && bus2.sram_oe_n, 1'b1);
        tick();
        check("t4_turn_w2", bus2.bus_t && bus2.sram_we_n && bus2.sram_oe_n, 1'b1);
        tick();
        check("t4_wr_we_n", bus2.sram_we_n, 1'b0);
        check("t4_wr_bus_t", bus2.bus_t, 1'b0);
        check("t4_wr_bus_o", bus2.bus_o, 16'hA5A5);
        tick();
        check("t4_wr_ack", bus2.ack_o, 2'b01);
        bus2.req_i = 2'b10; bus2.we_i = 2'b00; bus2.addr1_i = 18'h00005;
        released = 0;
        for (int c = 0; c < 12; c++) begin
            if (!bus2.sram_oe_n) break;
            if (bus2.bus_t && bus2.sram_we_n) released++;
            tick();
        end
        // The IDLE grant cycle plus exactly two TURN cycles separate we_n rising from oe_n falling
        check("t4_released_cycles", released, 1 + 2);
        check("t4_oe_c1", bus2.sram_oe_n, 1'b0);
        tick();
        check("t4_oe_c2", bus2.sram_oe_n, 1'b0);
        tick();
        check("t4_rd_ack", bus2.ack_o, 2'b10);
        check("t4_rd_data", bus2.rdata_o, 16'hA5A5);
        bus2.req_i = 2'b00;

        // Reset during the first READ cycle aborts the read
        sram_mem[18'h00042] = 16'h4242;
        bus.req_i = 2'b01; bus.we_i = 2'b00; bus.addr0_i = 18'h00042;
        tick();
        check("t5_in_read", bus.sram_oe_n, 1'b0);
        reset = 1'b1;
        tick();
        check("t5_oe_n", bus.sram_oe_n, 1'b1);
        check("t5_bus_t", bus.bus_t, 1'b1);
        check("t5_ack", bus.ack_o, 2'b00);
        check("t5_rdata", bus.rdata_o, 16'h0);
        reset = 1'b0;
        bus.req_i = 2'b00;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("t5_no_ack", bus.ack_o, 2'b00);
            check("t5_idle_oe", bus.sram_oe_n, 1'b1);
        end

        // Randomised traffic against the requester/memory model
        for (int c = 0; c < 10000; c++) begin
            drive_random(1'b1);
            tick();
            monitor_cycle();
        end
        for (int c = 0; c < 40 && (pend[0] || pend[1]); c++) begin
            drive_random(1'b0);
            tick();
            monitor_cycle();
        end
        check("drain_port0", pend[0], 1'b0);
        check("drain_port1", pend[1], 1'b0);
        check("one_ack_per_request", n_acked, n_issued);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
